// File: rtl/pipeline_if_pkg.sv
// -----------------------------------------------------------------------------
// pipeline_if_pkg
//   Shared definitions for the instruction-fetch stage and its neighbours:
//   next-PC select encodings, reset/vector addresses, the bubble (NOP) word
//   and a PC increment helper that never lets a carry reach PC[31].
// -----------------------------------------------------------------------------
package pipeline_if_pkg;

    // Next-PC select codes driven by decode. Codes 6 and 7 are reserved and
    // are treated as sequential fetch.
    typedef enum logic [2:0] {
        PCSRC_SEQ    = 3'd0,
        PCSRC_BRANCH = 3'd1,
        PCSRC_JUMP   = 3'd2,
        PCSRC_JR     = 3'd3,
        PCSRC_ILLOP  = 3'd4,
        PCSRC_XADR   = 3'd5
    } pcsrc_e;

    localparam logic [31:0] RESET_PC_DEF  = 32'h8000_0000;
    localparam logic [31:0] ILLOP_VEC_DEF = 32'h8000_0004;
    localparam logic [31:0] XADR_VEC_DEF  = 32'h8000_0008;
    localparam logic [31:0] NOP_WORD      = 32'h0000_0000;

    // PC[31] is the kernel-mode flag, so the increment is confined to the
    // low 31 bits and bit 31 is carried through unchanged.
    function automatic logic [31:0] pc_increment(input logic [31:0] pc);
        pc_increment = {pc[31], pc[30:0] + 31'd4};
    endfunction

endpackage

// File: rtl/pipeline_if_pc_next_mux.sv
// -----------------------------------------------------------------------------
// pipeline_if_pc_next_mux
//   Pure combinational next-PC selection for the fetch stage.
//   Ports:
//     pc           in  32  current PC
//     pcsrc        in   3  decode next-PC select
//     branch_taken in   1  qualifies a branch select
//     con_ba       in  32  branch target (bit 31 replaced by current PC[31])
//     jt           in  26  jump target field
//     jr_target    in  32  register jump target (full 32 bits, may leave kernel)
//     pc_in        in  32  PC+4 of the instruction in decode (upper nibble source)
//     pc_plus4     out 32  sequential successor of pc
//     pc_next      out 32  selected next PC
//     redirect     out  1  1 when the selected PC is not the sequential one
// -----------------------------------------------------------------------------
module pipeline_if_pc_next_mux
    import pipeline_if_pkg::*;
#(
    parameter logic [31:0] ILLOP_VEC = ILLOP_VEC_DEF,
    parameter logic [31:0] XADR_VEC  = XADR_VEC_DEF
) (
    input  logic [31:0] pc,
    input  logic [2:0]  pcsrc,
    input  logic        branch_taken,
    input  logic [31:0] con_ba,
    input  logic [25:0] jt,
    input  logic [31:0] jr_target,
    input  logic [31:0] pc_in,
    output logic [31:0] pc_plus4,
    output logic [31:0] pc_next,
    output logic        redirect
);

    logic [31:0] branch_tgt;
    logic [31:0] jump_tgt;

    assign pc_plus4 = pc_increment(pc);

    // Branch and j/jal targets must not change the kernel-mode bit, so bit 31
    // is overwritten with the current PC[31] whatever decode supplied.
    always_comb begin
        branch_tgt     = con_ba;
        branch_tgt[31] = pc[31];

        jump_tgt       = pc_in;
        jump_tgt[27:0] = {jt, 2'b00};
        jump_tgt[31]   = pc[31];
    end

    always_comb begin
        pc_next  = pc_plus4;
        redirect = 1'b0;
        case (pcsrc)
            PCSRC_BRANCH: begin
                if (branch_taken) begin
                    pc_next  = branch_tgt;
                    redirect = 1'b1;
                end
            end
            PCSRC_JUMP: begin
                pc_next  = jump_tgt;
                redirect = 1'b1;
            end
            PCSRC_JR: begin
                pc_next  = jr_target;
                redirect = 1'b1;
            end
            PCSRC_ILLOP: begin
                pc_next  = ILLOP_VEC;
                redirect = 1'b1;
            end
            PCSRC_XADR: begin
                pc_next  = XADR_VEC;
                redirect = 1'b1;
            end
            default: begin
                pc_next  = pc_plus4;
                redirect = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/pipeline_if.sv
// -----------------------------------------------------------------------------
// pipeline_if
//   Instruction-fetch stage of the 5-stage MIPS pipeline. Holds the PC, drives
//   the instruction ROM address and owns the IF/ID pipeline register.
//   Ports:
//     clk             in   1  clock, rising edge
//     reset           in   1  asynchronous, active-high
//     im_addr         out 32  instruction ROM byte address (= PC)
//     im_data         in  32  instruction word read combinationally at im_addr
//     stall           in   1  hold PC and IF/ID register
//     id_pcsrc        in   3  decode next-PC select
//     id_branch_taken in   1  branch condition true
//     id_con_ba       in  32  branch target
//     id_jt           in  26  jump target field
//     id_jr_target    in  32  register jump target
//     id_pc_in        in  32  PC+4 of instruction in decode
//     id_pc           out 32  IF/ID: PC+4 of fetched instruction
//     id_instruction  out 32  IF/ID: fetched instruction, 0 = bubble
//     id_valid        out  1  IF/ID: 1 = real fetched instruction
// -----------------------------------------------------------------------------
module pipeline_if
    import pipeline_if_pkg::*;
#(
    parameter logic [31:0] RESET_PC  = RESET_PC_DEF,
    parameter logic [31:0] ILLOP_VEC = ILLOP_VEC_DEF,
    parameter logic [31:0] XADR_VEC  = XADR_VEC_DEF
) (
    input  logic        clk,
    input  logic        reset,
    output logic [31:0] im_addr,
    input  logic [31:0] im_data,
    input  logic        stall,
    input  logic [2:0]  id_pcsrc,
    input  logic        id_branch_taken,
    input  logic [31:0] id_con_ba,
    input  logic [25:0] id_jt,
    input  logic [31:0] id_jr_target,
    input  logic [31:0] id_pc_in,
    output logic [31:0] id_pc,
    output logic [31:0] id_instruction,
    output logic        id_valid
);

    logic [31:0] pc_reg;
    logic [31:0] id_pc_reg;
    logic [31:0] id_instr_reg;
    logic        id_valid_reg;

    logic [31:0] pc_plus4;
    logic [31:0] pc_next;
    logic        redirect;

    pipeline_if_pc_next_mux #(
        .ILLOP_VEC (ILLOP_VEC),
        .XADR_VEC  (XADR_VEC)
    ) u_pc_next_mux (
        .pc           (pc_reg),
        .pcsrc        (id_pcsrc),
        .branch_taken (id_branch_taken),
        .con_ba       (id_con_ba),
        .jt           (id_jt),
        .jr_target    (id_jr_target),
        .pc_in        (id_pc_in),
        .pc_plus4     (pc_plus4),
        .pc_next      (pc_next),
        .redirect     (redirect)
    );

    // Priority: reset > stall > redirect > sequential. During a stall the
    // redirect request is ignored; decode presents it again once unstalled.
    // A redirect squashes the word fetched this cycle (single delay-slot
    // squash) but still records PC+4 in the IF/ID register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pc_reg       <= RESET_PC;
            id_pc_reg    <= 32'h0;
            id_instr_reg <= NOP_WORD;
            id_valid_reg <= 1'b0;
        end else if (!stall) begin
            pc_reg    <= pc_next;
            id_pc_reg <= pc_plus4;
            if (redirect) begin
                id_instr_reg <= NOP_WORD;
                id_valid_reg <= 1'b0;
            end else begin
                id_instr_reg <= im_data;
                id_valid_reg <= 1'b1;
            end
        end
    end

    assign im_addr        = pc_reg;
    assign id_pc          = id_pc_reg;
    assign id_instruction = id_instr_reg;
    assign id_valid       = id_valid_reg;

endmodule

// File: tb/tb_pipeline_if.sv
module tb_pipeline_if;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] im_addr;
    logic [31:0] im_data;
    logic        stall;
    logic [2:0]  id_pcsrc;
    logic        id_branch_taken;
    logic [31:0] id_con_ba;
    logic [25:0] id_jt;
    logic [31:0] id_jr_target;
    logic [31:0] id_pc_in;
    logic [31:0] id_pc;
    logic [31:0] id_instruction;
    logic        id_valid;

    int n_cmp = 0;
    int n_err = 0;

    // reference state
    logic [31:0] m_pc;
    logic [31:0] m_id_pc;
    logic [31:0] m_id_instr;
    logic        m_id_valid;

    always #5 clk = ~clk;

    pipeline_if dut (
        .clk             (clk),
        .reset           (reset),
        .im_addr         (im_addr),
        .im_data         (im_data),
        .stall           (stall),
        .id_pcsrc        (id_pcsrc),
        .id_branch_taken (id_branch_taken),
        .id_con_ba       (id_con_ba),
        .id_jt           (id_jt),
        .id_jr_target    (id_jr_target),
        .id_pc_in        (id_pc_in),
        .id_pc           (id_pc),
        .id_instruction  (id_instruction),
        .id_valid        (id_valid)
    );

    // Instruction ROM contents: fixed first word, address hash elsewhere.
    function automatic logic [31:0] rom_word(input logic [31:0] a);
        if (a == 32'h8000_0000) return 32'h2008_0001;
        return (a * 32'h9E37_79B9) ^ 32'h5A5A_1234;
    endfunction

    assign im_data = rom_word(im_addr);

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %08h expected %08h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        check({tag, "_addr"},  im_addr, m_pc);
        check({tag, "_idpc"},  id_pc, m_id_pc);
        check({tag, "_instr"}, id_instruction, m_id_instr);
        check({tag, "_valid"}, {31'd0, id_valid}, {31'd0, m_id_valid});
        $display("%s: pc=%08h id_pc=%08h instr=%08h valid=%0d", tag, im_addr, id_pc, id_instruction, id_valid);
    endtask

    task automatic model_reset();
        m_pc       = 32'h8000_0000;
        m_id_pc    = 32'h0;
        m_id_instr = 32'h0;
        m_id_valid = 1'b0;
    endtask

    // Architectural next-PC rules applied to the reference state.
    task automatic model_edge(input logic s, input logic [2:0] src, input logic tk,
                              input logic [31:0] cba, input logic [25:0] jt,
                              input logic [31:0] jr, input logic [31:0] pin);
        logic [31:0] seq;
        logic [31:0] tgt;
        logic        redir;
        if (s) return;
        seq   = {m_pc[31], m_pc[30:0] + 31'd4};
        redir = 1'b1;
        tgt   = seq;
        if (src == 3'd1 && tk)  tgt = {m_pc[31], cba[30:0]};
        else if (src == 3'd2)   tgt = {m_pc[31], pin[30:28], jt, 2'b00};
        else if (src == 3'd3)   tgt = jr;
        else if (src == 3'd4)   tgt = 32'h8000_0004;
        else if (src == 3'd5)   tgt = 32'h8000_0008;
        else                    redir = 1'b0;
        m_id_instr = redir ? 32'h0 : rom_word(m_pc);
        m_id_valid = !redir;
        m_id_pc    = seq;
        m_pc       = redir ? tgt : seq;
    endtask

    // Drive at negedge, clock one edge, check at the following negedge.
    task automatic step(input string tag, input logic s, input logic [2:0] src, input logic tk,
                        input logic [31:0] cba, input logic [25:0] jt,
                        input logic [31:0] jr, input logic [31:0] pin);
        stall = s; id_pcsrc = src; id_branch_taken = tk;
        id_con_ba = cba; id_jt = jt; id_jr_target = jr; id_pc_in = pin;
        @(posedge clk);
        model_edge(s, src, tk, cba, jt, jr, pin);
        @(negedge clk);
        check_all(tag);
    endtask

    // Assert reset between edges; outputs must respond without a clock edge.
    task automatic async_reset(input string tag);
        #2;
        reset = 1'b1;
        #1;
        model_reset();
        check_all(tag);
        @(negedge clk);
        reset = 1'b0;
    endtask

    initial begin
        reset = 1'b1; stall = 1'b0; id_pcsrc = 3'd0; id_branch_taken = 1'b0;
        id_con_ba = 32'h0; id_jt = 26'h0; id_jr_target = 32'h0; id_pc_in = 32'h0;
        model_reset();
        repeat (2) @(negedge clk);
        check_all("reset");
        reset = 1'b0;
        #1;
        check_all("release");

        // 1/2: first fetch and sequential run, untaken branch stays sequential
        step("t1_fetch", 0, 3'd0, 0, 0, 0, 0, 0);
        check("t1_instr_const", id_instruction, 32'h2008_0001);
        check("t1_idpc_const", id_pc, 32'h8000_0004);
        step("t2_seq", 0, 3'd0, 0, 0, 0, 0, 0);
        step("t2_seq", 0, 3'd0, 0, 0, 0, 0, 0);
        check("t2_addr_const", im_addr, 32'h8000_000C);
        step("t2_untaken", 0, 3'd1, 0, 32'h8000_0040, 0, 0, 0);
        check("t2_untaken_const", im_addr, 32'h8000_0010);

        // 3: taken branch, bubble for one cycle
        step("t3_branch", 0, 3'd1, 1, 32'h8000_0040, 0, 0, 0);
        check("t3_addr_const", im_addr, 32'h8000_0040);
        check("t3_valid_const", {31'd0, id_valid}, 32'd0);
        step("t3_after", 0, 3'd0, 0, 0, 0, 0, 0);

        // 4: stall masks a jump, jump taken once stall drops
        step("t4_stall", 1, 3'd2, 0, 0, 26'h000_0123, 0, 32'h9000_0000);
        check("t4_hold_const", im_addr, 32'h8000_0044);
        step("t4_jump", 0, 3'd2, 0, 0, 26'h000_0123, 0, 32'h9000_0000);
        check("t4_jump_const", im_addr, 32'h9000_048C);

        // 5: jr leaves kernel mode; a following j cannot set PC[31]
        step("t5_br", 0, 3'd1, 1, 32'h0000_0100, 0, 0, 0);
        check("t5_br_const", im_addr, 32'h8000_0100);
        step("t5_jr", 0, 3'd3, 0, 0, 0, 32'h0000_0200, 0);
        check("t5_jr_const", im_addr, 32'h0000_0200);
        step("t5_j", 0, 3'd2, 0, 0, 26'h3FF_FFFF, 0, 32'hF000_0000);
        check("t5_j_const", im_addr, 32'h7FFF_FFFC);
        step("t5_seq", 0, 3'd0, 0, 0, 0, 0, 0);

        // 6: ILLOP from user mode, then reset mid-stall
        step("t6_illop", 0, 3'd4, 0, 0, 0, 0, 0);
        check("t6_illop_const", im_addr, 32'h8000_0004);
        step("t6_seq", 0, 3'd0, 0, 0, 0, 0, 0);
        stall = 1'b1;
        async_reset("t6_reset");
        check("t6_reset_const", im_addr, 32'h8000_0000);

        // randomized traffic
        for (int i = 0; i < 400; i++) begin
            logic        s;
            logic [2:0]  src;
            int          r;
            s   = ($urandom % 5) == 0;
            r   = $urandom % 16;
            src = (r < 8) ? 3'd0 : 3'(r - 8);
            if (($urandom % 64) == 0) begin
                stall = s;
                async_reset("rnd_reset");
            end else begin
                step("rnd", s, src, 1'($urandom), $urandom, 26'($urandom),
                     $urandom, $urandom);
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
